// File: rtl/id_ex_pkg.sv
// Shared definitions for the ID/EX stage: control-bundle layout and register-file constants.
// The control bundle is {regWrite,memRead,memWrite,memToReg,aluSrc,regDst,aluOp[3:0]}, MSB first.
package id_ex_pkg;

    localparam int CTLW         = 10;
    localparam int CTL_REGWRITE = 9;
    localparam int CTL_MEMREAD  = 8;
    localparam int CTL_MEMWRITE = 7;
    localparam int CTL_MEMTOREG = 6;
    localparam int CTL_ALUSRC   = 5;
    localparam int CTL_REGDST   = 4;
    localparam int CTL_ALUOP    = 0;
    localparam int CTL_ALUOP_W  = 4;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef logic [CTLW-1:0] ctl_t;

endpackage

// File: rtl/id_ex_stage_bypass.sv
// Operand select for one GPR read port: $0 reads as zero, otherwise the same-cycle WB write
// takes precedence over the (stale) combinational GPR read data.
module id_bypass_mux
    import id_ex_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic [AW-1:0] idx_i,
    input  logic [DW-1:0] gpr_i,
    input  logic          wb_we_i,
    input  logic [AW-1:0] wb_rw_i,
    input  logic [DW-1:0] wb_wd_i,
    output logic [DW-1:0] op_o
);

    logic is_zero;
    logic wb_hit;

    // wb_rw==0 can never hit because a zero index is resolved first.
    assign is_zero = (idx_i == AW'(REG_ZERO));
    assign wb_hit  = wb_we_i && (wb_rw_i == idx_i);

    always_comb begin
        op_o = gpr_i;
        if (is_zero) begin
            op_o = '0;
        end else if (wb_hit) begin
            op_o = wb_wd_i;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures operands (with WB bypass and $0 forcing), immediate, indices
// and control; supports stall/flush and raises the load-use stall request toward IF/ID.
module id_ex_stage
    import id_ex_pkg::*;
#(
    parameter int DW  = 32,
    parameter int AW  = 5,
    parameter int PCW = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    input  logic [PCW-1:0]  id_pc,
    input  logic [AW-1:0]   id_rs,
    input  logic [AW-1:0]   id_rt,
    input  logic [AW-1:0]   id_rd,
    input  logic [DW-1:0]   id_rd1,
    input  logic [DW-1:0]   id_rd2,
    input  logic [DW-1:0]   id_imm,
    input  logic [CTLW-1:0] id_ctl,
    input  logic            id_uses_rt,
    input  logic            wb_regWrite,
    input  logic [AW-1:0]   wb_rw,
    input  logic [DW-1:0]   wb_wd,
    input  logic            stall,
    input  logic            flush,
    output logic            ex_valid,
    output logic [PCW-1:0]  ex_pc,
    output logic [DW-1:0]   ex_a,
    output logic [DW-1:0]   ex_b,
    output logic [DW-1:0]   ex_imm,
    output logic [AW-1:0]   ex_rs,
    output logic [AW-1:0]   ex_rt,
    output logic [AW-1:0]   ex_dst,
    output logic [CTLW-1:0] ex_ctl,
    output logic            load_use_stall
);

    logic            valid_q, valid_d;
    logic [PCW-1:0]  pc_q,    pc_d;
    logic [DW-1:0]   a_q,     a_d;
    logic [DW-1:0]   b_q,     b_d;
    logic [DW-1:0]   imm_q,   imm_d;
    logic [AW-1:0]   rs_q,    rs_d;
    logic [AW-1:0]   rt_q,    rt_d;
    logic [AW-1:0]   dst_q,   dst_d;
    logic [CTLW-1:0] ctl_q,   ctl_d;

    logic [DW-1:0]   op_a;
    logic [DW-1:0]   op_b;
    logic [AW-1:0]   dst_sel;

    id_bypass_mux #(.DW(DW), .AW(AW)) u_byp_a (
        .idx_i   (id_rs),
        .gpr_i   (id_rd1),
        .wb_we_i (wb_regWrite),
        .wb_rw_i (wb_rw),
        .wb_wd_i (wb_wd),
        .op_o    (op_a)
    );

    id_bypass_mux #(.DW(DW), .AW(AW)) u_byp_b (
        .idx_i   (id_rt),
        .gpr_i   (id_rd2),
        .wb_we_i (wb_regWrite),
        .wb_rw_i (wb_rw),
        .wb_wd_i (wb_wd),
        .op_o    (op_b)
    );

    assign dst_sel = id_ctl[CTL_REGDST] ? id_rd : id_rt;

    // Priority: flush > stall > load. A held entry is not re-bypassed; EX forwarding covers it.
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        a_d     = a_q;
        b_d     = b_q;
        imm_d   = imm_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        dst_d   = dst_q;
        ctl_d   = ctl_q;
        if (flush) begin
            valid_d = 1'b0;
            pc_d    = '0;
            a_d     = '0;
            b_d     = '0;
            imm_d   = '0;
            rs_d    = '0;
            rt_d    = '0;
            dst_d   = '0;
            ctl_d   = '0;
        end else if (!stall) begin
            valid_d = id_valid;
            pc_d    = id_pc;
            a_d     = op_a;
            b_d     = op_b;
            imm_d   = id_imm;
            rs_d    = id_rs;
            rt_d    = id_rt;
            dst_d   = id_valid ? dst_sel : '0;
            ctl_d   = id_valid ? id_ctl  : '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            imm_q   <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            dst_q   <= '0;
            ctl_q   <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            imm_q   <= imm_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            dst_q   <= dst_d;
            ctl_q   <= ctl_d;
        end
    end

    assign ex_valid = valid_q;
    assign ex_pc    = pc_q;
    assign ex_a     = a_q;
    assign ex_b     = b_q;
    assign ex_imm   = imm_q;
    assign ex_rs    = rs_q;
    assign ex_rt    = rt_q;
    assign ex_dst   = dst_q;
    assign ex_ctl   = ctl_q;

    // A load in EX whose result a valid ID instruction needs next cycle; $0 is never a hazard.
    assign load_use_stall = valid_q && ctl_q[CTL_MEMREAD] && (dst_q != AW'(REG_ZERO)) && id_valid &&
                            ((dst_q == id_rs) || (id_uses_rt && (dst_q == id_rt)));

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed scoreboard bench for id_ex_stage: expected register contents are pushed as each edge's
// stimulus is applied and popped/compared one cycle later.
module tb_id_ex_stage;

    localparam logic [9:0] C_RW  = 10'h200;
    localparam logic [9:0] C_MR  = 10'h100;
    localparam logic [9:0] C_ALS = 10'h020;
    localparam logic [9:0] C_RD  = 10'h010;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_rd1, id_rd2, id_imm;
    logic [9:0]  id_ctl;
    logic        id_uses_rt;
    logic        wb_regWrite;
    logic [4:0]  wb_rw;
    logic [31:0] wb_wd;
    logic        stall, flush;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_a, ex_b, ex_imm;
    logic [4:0]  ex_rs, ex_rt, ex_dst;
    logic [9:0]  ex_ctl;
    logic        load_use_stall;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dst;
        logic [9:0]  ctl;
    } exp_t;

    exp_t m;
    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    id_ex_stage dut (
        .clk            (clk),
        .reset          (reset),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_rd          (id_rd),
        .id_rd1         (id_rd1),
        .id_rd2         (id_rd2),
        .id_imm         (id_imm),
        .id_ctl         (id_ctl),
        .id_uses_rt     (id_uses_rt),
        .wb_regWrite    (wb_regWrite),
        .wb_rw          (wb_rw),
        .wb_wd          (wb_wd),
        .stall          (stall),
        .flush          (flush),
        .ex_valid       (ex_valid),
        .ex_pc          (ex_pc),
        .ex_a           (ex_a),
        .ex_b           (ex_b),
        .ex_imm         (ex_imm),
        .ex_rs          (ex_rs),
        .ex_rt          (ex_rt),
        .ex_dst         (ex_dst),
        .ex_ctl         (ex_ctl),
        .load_use_stall (load_use_stall)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] opnd(input logic [4:0] idx, input logic [31:0] gpr);
        if (idx == 5'd0) return 32'h0;
        if (wb_regWrite && (wb_rw == idx)) return wb_wd;
        return gpr;
    endfunction

    task automatic chk_all(input string tag, input exp_t e);
        chk({tag, ".valid"}, 64'(ex_valid), 64'(e.valid));
        chk({tag, ".pc"},    64'(ex_pc),    64'(e.pc));
        chk({tag, ".a"},     64'(ex_a),     64'(e.a));
        chk({tag, ".b"},     64'(ex_b),     64'(e.b));
        chk({tag, ".imm"},   64'(ex_imm),   64'(e.imm));
        chk({tag, ".rs"},    64'(ex_rs),    64'(e.rs));
        chk({tag, ".rt"},    64'(ex_rt),    64'(e.rt));
        chk({tag, ".dst"},   64'(ex_dst),   64'(e.dst));
        chk({tag, ".ctl"},   64'(ex_ctl),   64'(e.ctl));
    endtask

    // Predict the register contents after the coming edge, then compare once it has happened.
    task automatic cycle(input string tag);
        exp_t n;
        exp_t e;
        if (flush) begin
            n = '0;
        end else if (stall) begin
            n = m;
        end else begin
            n.valid = id_valid;
            n.pc    = id_pc;
            n.a     = opnd(id_rs, id_rd1);
            n.b     = opnd(id_rt, id_rd2);
            n.imm   = id_imm;
            n.rs    = id_rs;
            n.rt    = id_rt;
            n.dst   = !id_valid ? 5'd0 : (id_ctl[4] ? id_rd : id_rt);
            n.ctl   = id_valid ? id_ctl : 10'd0;
        end
        sb.push_back(n);
        m = n;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL %s: scoreboard empty, observed nothing expected an entry", tag);
        end else begin
            e = sb.pop_front();
            chk_all(tag, e);
        end
    endtask

    task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                          input logic [31:0] imm, input logic [9:0] ctl, input logic urt);
        id_valid = v;  id_pc = pc;   id_rs = rs;   id_rt = rt;   id_rd = rd;
        id_rd1 = d1;   id_rd2 = d2;  id_imm = imm; id_ctl = ctl; id_uses_rt = urt;
    endtask

    task automatic set_wb(input logic we, input logic [4:0] rw, input logic [31:0] wd);
        wb_regWrite = we; wb_rw = rw; wb_wd = wd;
    endtask

    initial begin
        exp_t held;
        reset = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        set_id(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 10'h0, 1'b0);
        set_wb(1'b0, 5'd0, 32'h0);
        m = '0;
        #12;
        chk_all("reset_init", '0);
        chk("reset_init.lus", 64'(load_use_stall), 64'd0);
        reset = 1'b1;

        // WB bypass into A; B reads GPR
        set_id(1'b1, 32'h104, 5'd5, 5'd9, 5'd10, 32'h11, 32'h22, 32'h7, C_RW | C_RD | 10'h2, 1'b1);
        set_wb(1'b1, 5'd5, 32'hDEAD);
        cycle("bypass_hit");
        chk("bypass_hit.ex_a", 64'(ex_a), 64'h0000DEAD);
        set_wb(1'b1, 5'd6, 32'hDEAD);
        cycle("bypass_miss");
        chk("bypass_miss.ex_a", 64'(ex_a), 64'h11);

        // $0 forcing and dual bypass
        set_id(1'b1, 32'h108, 5'd0, 5'd3, 5'd4, 32'h1234, 32'h33, 32'h0, C_RW | C_RD, 1'b1);
        set_wb(1'b1, 5'd0, 32'hFF);
        cycle("zero_reg");
        chk("zero_reg.ex_a", 64'(ex_a), 64'h0);
        set_id(1'b1, 32'h10C, 5'd7, 5'd7, 5'd8, 32'h70, 32'h71, 32'h0, C_RW | C_RD, 1'b1);
        set_wb(1'b1, 5'd7, 32'hBEEF);
        cycle("dual_bypass");
        chk("dual_bypass.ex_a", 64'(ex_a), 64'hBEEF);
        chk("dual_bypass.ex_b", 64'(ex_b), 64'hBEEF);
        set_wb(1'b0, 5'd7, 32'hBEEF);
        cycle("wb_disabled");
        chk("wb_disabled.ex_a", 64'(ex_a), 64'h70);

        // destination select and bubble load
        set_id(1'b1, 32'h110, 5'd1, 5'd4, 5'd3, 32'h1, 32'h2, 32'h0, C_RW | C_RD, 1'b1);
        cycle("dst_rd");
        chk("dst_rd.ex_dst", 64'(ex_dst), 64'd3);
        id_ctl = C_RW | C_ALS;
        cycle("dst_rt");
        chk("dst_rt.ex_dst", 64'(ex_dst), 64'd4);
        id_valid = 1'b0;
        cycle("bubble_load");
        chk("bubble_load.ex_ctl", 64'(ex_ctl), 64'd0);
        chk("bubble_load.ex_dst", 64'(ex_dst), 64'd0);

        // stall holds everything, even with a WB hitting the held source
        set_id(1'b1, 32'h200, 5'd12, 5'd13, 5'd14, 32'hA1, 32'hB2, 32'hC3, C_RW | C_RD | 10'h5, 1'b1);
        set_wb(1'b0, 5'd0, 32'h0);
        cycle("pre_stall");
        held = m;
        stall = 1'b1;
        set_id(1'b1, 32'h204, 5'd12, 5'd2, 5'd2, 32'h99, 32'h98, 32'h97, C_MR, 1'b1);
        set_wb(1'b1, 5'd12, 32'h5555);
        for (int i = 0; i < 3; i++) begin
            cycle("stall");
            chk("stall.ex_a", 64'(ex_a), 64'(held.a));
        end
        flush = 1'b1;
        cycle("stall_flush");
        chk("stall_flush.ex_valid", 64'(ex_valid), 64'd0);
        chk("stall_flush.ex_ctl", 64'(ex_ctl), 64'd0);
        stall = 1'b0;
        flush = 1'b0;
        set_wb(1'b0, 5'd0, 32'h0);

        // load-use hazard detection
        set_id(1'b1, 32'h300, 5'd29, 5'd8, 5'd0, 32'h1000, 32'h0, 32'h4, C_RW | C_MR | C_ALS, 1'b0);
        cycle("lw_load");
        set_id(1'b1, 32'h304, 5'd8, 5'd9, 5'd10, 32'h0, 32'h0, 32'h0, C_RW | C_RD, 1'b1);
        #1 chk("lus_rs", 64'(load_use_stall), 64'd1);
        id_rs = 5'd1; id_rt = 5'd8; id_uses_rt = 1'b0;
        #1 chk("lus_rt_unused", 64'(load_use_stall), 64'd0);
        id_uses_rt = 1'b1;
        #1 chk("lus_rt_used", 64'(load_use_stall), 64'd1);
        id_valid = 1'b0;
        #1 chk("lus_id_invalid", 64'(load_use_stall), 64'd0);
        id_valid = 1'b1;
        flush = 1'b1;
        cycle("lus_bubble");
        chk("lus_bubble.lus", 64'(load_use_stall), 64'd0);
        flush = 1'b0;
        set_id(1'b1, 32'h308, 5'd29, 5'd0, 5'd0, 32'h1000, 32'h0, 32'h8, C_RW | C_MR | C_ALS, 1'b0);
        cycle("lw_dst0");
        set_id(1'b1, 32'h30C, 5'd0, 5'd0, 5'd5, 32'h0, 32'h0, 32'h0, C_RW | C_RD, 1'b1);
        #1 chk("lus_dst0", 64'(load_use_stall), 64'd0);

        // asynchronous reset mid-stream, then a normal load after release
        set_id(1'b1, 32'h400, 5'd8, 5'd9, 5'd11, 32'h44, 32'h55, 32'h66, C_RW | C_RD | 10'h3, 1'b1);
        cycle("pre_reset");
        #2;
        reset = 1'b0;
        #1;
        m = '0;
        sb.delete();
        chk_all("reset_mid", '0);
        chk("reset_mid.lus", 64'(load_use_stall), 64'd0);
        #2 reset = 1'b1;
        set_id(1'b1, 32'h404, 5'd6, 5'd7, 5'd15, 32'h123, 32'h456, 32'h789, C_RW | C_RD, 1'b1);
        cycle("post_reset");
        chk("post_reset.ex_valid", 64'(ex_valid), 64'd1);
        chk("post_reset.ex_dst", 64'(ex_dst), 64'd15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
